// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the two-port memory arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Which requester owns the memory port
   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } gnt_t;

   // Read data returned to the requester when a transfer is aborted
   localparam int ABORT_DATA = 0;

   // Wide enough for the largest legal TIMEOUT (65535)
   localparam int CNT_W = 16;

   // Counter value at which a still-unanswered transfer is aborted
   function automatic logic [CNT_W-1:0] timeout_last(input int unsigned t);
      return CNT_W'(t - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Combinational two-way round-robin pick between the
//                instruction and data requesters.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  gnt_t last_grant,
   output logic valid,
   output gnt_t grant
);

   // A lone request wins outright; a tie goes to the port not served last
   always_comb begin
      valid = i_req | d_req;
      grant = GNT_I;
      if (i_req && d_req) begin
         grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
      end else if (d_req) begin
         grant = GNT_D;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-ported memory between the instruction
//                fetch port and the data port. Round-robin, one transfer in
//                flight, per-transfer timeout with sticky error flag.
//                All outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
)
(
   input  logic          clk,
   input  logic          rst,
   // instruction fetch port
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_ack,
   // data port
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   // memory controller port
   output logic          m_req,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   input  logic          m_ready,
   // status
   output logic          busy,
   output logic          err
);

   localparam logic [CNT_W-1:0] C_CNT_LAST   = timeout_last(TIMEOUT);
   localparam logic [DW-1:0]    C_ABORT_DATA = DW'(ABORT_DATA);

   // registered state
   state_t            r_state;
   gnt_t              r_last_grant;
   gnt_t              r_grant;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_m_req;
   logic              r_m_we;
   logic [AW-1:0]     r_m_addr;
   logic [DW-1:0]     r_m_wdata;
   logic              r_i_ack;
   logic              r_d_ack;
   logic [DW-1:0]     r_i_rdata;
   logic [DW-1:0]     r_d_rdata;
   logic              r_busy;
   logic              r_err;

   // next-state values
   state_t            w_state_n;
   gnt_t              w_last_grant_n;
   gnt_t              w_grant_n;
   logic [CNT_W-1:0]  w_cnt_n;
   logic              w_m_req_n;
   logic              w_m_we_n;
   logic [AW-1:0]     w_m_addr_n;
   logic [DW-1:0]     w_m_wdata_n;
   logic              w_i_ack_n;
   logic              w_d_ack_n;
   logic [DW-1:0]     w_i_rdata_n;
   logic [DW-1:0]     w_d_rdata_n;
   logic              w_busy_n;
   logic              w_err_n;

   // arbitration result
   logic              w_pick_valid;
   gnt_t              w_pick;

   rr_pick2 u_pick (
      .i_req      (i_req),
      .d_req      (d_req),
      .last_grant (r_last_grant),
      .valid      (w_pick_valid),
      .grant      (w_pick)
   );

   // FSM next-state and next-output computation
   always_comb begin
      w_state_n      = r_state;
      w_last_grant_n = r_last_grant;
      w_grant_n      = r_grant;
      w_cnt_n        = r_cnt;
      w_m_req_n      = r_m_req;
      w_m_we_n       = r_m_we;
      w_m_addr_n     = r_m_addr;
      w_m_wdata_n    = r_m_wdata;
      w_i_ack_n      = 1'b0;
      w_d_ack_n      = 1'b0;
      w_i_rdata_n    = r_i_rdata;
      w_d_rdata_n    = r_d_rdata;
      w_err_n        = r_err;

      case (r_state)
         ST_IDLE: begin
            if (w_pick_valid) begin
               w_grant_n      = w_pick;
               w_last_grant_n = w_pick;
               w_cnt_n        = '0;
               w_m_req_n      = 1'b1;
               if (w_pick == GNT_D) begin
                  w_m_we_n    = d_we;
                  w_m_addr_n  = d_addr;
                  w_m_wdata_n = d_wdata;
               end else begin
                  // instruction fetches are always reads; wdata is left as is
                  w_m_we_n    = 1'b0;
                  w_m_addr_n  = i_addr;
               end
               w_state_n = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (m_ready) begin
               // a response in the last allowed cycle still counts as success
               if (r_grant == GNT_D) begin
                  w_d_rdata_n = m_rdata;
                  w_d_ack_n   = 1'b1;
               end else begin
                  w_i_rdata_n = m_rdata;
                  w_i_ack_n   = 1'b1;
               end
               w_m_req_n = 1'b0;
               w_state_n = ST_DONE;
            end else if (r_cnt == C_CNT_LAST) begin
               // memory never answered: complete the requester with dummy data
               if (r_grant == GNT_D) begin
                  w_d_rdata_n = C_ABORT_DATA;
                  w_d_ack_n   = 1'b1;
               end else begin
                  w_i_rdata_n = C_ABORT_DATA;
                  w_i_ack_n   = 1'b1;
               end
               w_err_n   = 1'b1;
               w_m_req_n = 1'b0;
               w_state_n = ST_DONE;
            end else begin
               w_cnt_n = r_cnt + CNT_W'(1);
            end
         end

         ST_DONE: begin
            w_state_n = ST_IDLE;
         end

         default: begin
            w_state_n = ST_IDLE;
            w_m_req_n = 1'b0;
         end
      endcase

      w_busy_n = (w_state_n != ST_IDLE);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_n;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_last_grant <= GNT_I;
         r_grant      <= GNT_I;
         r_cnt        <= '0;
         r_m_req      <= 1'b0;
         r_m_we       <= 1'b0;
         r_m_addr     <= '0;
         r_m_wdata    <= '0;
         r_i_ack      <= 1'b0;
         r_d_ack      <= 1'b0;
         r_i_rdata    <= '0;
         r_d_rdata    <= '0;
         r_busy       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_last_grant <= w_last_grant_n;
         r_grant      <= w_grant_n;
         r_cnt        <= w_cnt_n;
         r_m_req      <= w_m_req_n;
         r_m_we       <= w_m_we_n;
         r_m_addr     <= w_m_addr_n;
         r_m_wdata    <= w_m_wdata_n;
         r_i_ack      <= w_i_ack_n;
         r_d_ack      <= w_d_ack_n;
         r_i_rdata    <= w_i_rdata_n;
         r_d_rdata    <= w_d_rdata_n;
         r_busy       <= w_busy_n;
         r_err        <= w_err_n;
      end
   end

   assign m_req   = r_m_req;
   assign m_we    = r_m_we;
   assign m_addr  = r_m_addr;
   assign m_wdata = r_m_wdata;
   assign i_ack   = r_i_ack;
   assign d_ack   = r_d_ack;
   assign i_rdata = r_i_rdata;
   assign d_rdata = r_d_rdata;
   assign busy    = r_busy;
   assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter (TIMEOUT = 8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic [DW-1:0] i_rdata;
   logic          i_ack;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [DW-1:0] d_rdata;
   logic          d_ack;
   logic          m_req;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata = '0;
   logic          m_ready = 1'b0;
   logic          busy;
   logic          err;

   mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_rdata (i_rdata),
      .i_ack   (i_ack),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_rdata (d_rdata),
      .d_ack   (d_ack),
      .m_req   (m_req),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata),
      .m_ready (m_ready),
      .busy    (busy),
      .err     (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   // reference model state: port served last (0=I, 1=D) and sticky error
   bit last    = 1'b0;
   bit exp_err = 1'b0;
   bit last_g  = 1'b0;
   int ack_cyc = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic raise_i(input logic [31:0] a);
      i_req  = 1'b1;
      i_addr = a;
   endtask

   task automatic raise_d(input bit we, input logic [31:0] a, input logic [31:0] wd);
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = a;
      d_wdata = wd;
   endtask

   task automatic do_reset();
      rst     = 1'b0;
      i_req   = 1'b0;
      d_req   = 1'b0;
      m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset ctl", {59'd0, m_req, m_we, i_ack, d_ack, busy, err}, 64'd0);
      chk("reset m_addr", m_addr, 0);
      chk("reset m_wdata", m_wdata, 0);
      chk("reset i_rdata", i_rdata, 0);
      chk("reset d_rdata", d_rdata, 0);
      rst     = 1'b1;
      last    = 1'b0;
      exp_err = 1'b0;
   endtask

   // One complete transfer, starting in IDLE with at least one request up.
   // delay = WAIT cycle in which m_ready rises; > TO means never.
   task automatic serve(input int delay, input bit fix, input logic [31:0] fixv, input bit rearm);
      bit          g;
      bit          ewe;
      bit          abort;
      bit          done;
      logic [31:0] ea;
      logic [31:0] ew;
      logic [31:0] rd;
      logic [31:0] erd;
      int          w;
      g   = (i_req && d_req) ? ~last : d_req;
      ea  = g ? d_addr : i_addr;
      ewe = g ? d_we : 1'b0;
      ew  = d_wdata;
      erd = '0;
      @(posedge clk); #1;
      chk("grant m_req", {63'd0, m_req}, 64'd1);
      chk("grant m_addr", m_addr, ea);
      chk("grant m_we", {63'd0, m_we}, {63'd0, ewe});
      if (g && ewe) chk("grant m_wdata", m_wdata, ew);
      chk("grant busy", {63'd0, busy}, 64'd1);
      last   = g;
      last_g = g;
      done   = 1'b0;
      w      = 0;
      while (!done && w < TO) begin
         w++;
         rd      = fix ? fixv : $urandom;
         m_ready = (w == delay);
         m_rdata = rd;
         i_addr  = $urandom;
         d_addr  = $urandom;
         d_wdata = $urandom;
         @(posedge clk); #1;
         if (w == delay || w == TO) begin
            done  = 1'b1;
            abort = (w != delay);
            if (abort) exp_err = 1'b1;
            erd = abort ? 32'd0 : rd;
            ack_cyc = cyc;
            chk("ack pair", {62'd0, i_ack, d_ack}, g ? 64'd1 : 64'd2);
            if (abort || !(g && ewe)) chk("ack rdata", g ? d_rdata : i_rdata, erd);
            chk("ack err", {63'd0, err}, {63'd0, exp_err});
            chk("ack m_req", {63'd0, m_req}, 64'd0);
         end else begin
            chk("wait m_req", {63'd0, m_req}, 64'd1);
            chk("wait m_addr", m_addr, ea);
            chk("wait acks", {62'd0, i_ack, d_ack}, 64'd0);
         end
      end
      // DONE cycle: m_ready here must be ignored; requester drops its request
      m_ready = 1'($urandom);
      if (g) d_req = 1'b0; else i_req = 1'b0;
      @(posedge clk); #1;
      chk("done->idle", {60'd0, i_ack, d_ack, busy, m_req}, 64'd0);
      chk("idle err", {63'd0, err}, {63'd0, exp_err});
      if (abort || !(g && ewe)) chk("rdata hold", g ? d_rdata : i_rdata, erd);
      m_ready = 1'($urandom);
      if (rearm) begin
         if (g) raise_d(1'($urandom), $urandom, $urandom);
         else   raise_i($urandom);
      end
   endtask

   initial begin
      int c0;
      int prev;

      do_reset();

      // idle with no request stays idle
      @(posedge clk); #1;
      chk("idle no req", {62'd0, busy, m_req}, 64'd0);

      // single instruction fetch, memory answers in 3rd WAIT cycle
      raise_i(32'h100);
      serve(3, 1'b1, 32'h8C08_0004, 1'b0);
      chk("t1 granted I", {63'd0, last_g}, 64'd0);
      chk("t1 rdata", i_rdata, 32'h8C08_0004);

      // simultaneous requests after reset: D first, then I
      do_reset();
      @(posedge clk); #1;
      raise_i(32'h300);
      raise_d(1'b1, 32'h200, 32'hDEAD_BEEF);
      c0 = cyc;
      serve(1, 1'b0, 32'h0, 1'b0);
      chk("t2 first is D", {63'd0, last_g}, 64'd1);
      chk("t2 D latency", 64'(ack_cyc - c0), 64'd2);
      serve(1, 1'b0, 32'h0, 1'b0);
      chk("t2 second is I", {63'd0, last_g}, 64'd0);
      chk("t2 I latency", 64'(ack_cyc - c0), 64'd5);

      // both held continuously: strict alternation, one ack per 3 cycles
      raise_i($urandom);
      raise_d(1'b0, $urandom, $urandom);
      prev = 0;
      for (int k = 0; k < 6; k++) begin
         serve(1, 1'b0, 32'h0, 1'b1);
         chk("alt grant", {63'd0, last_g}, (k % 2 == 0) ? 64'd1 : 64'd0);
         if (k > 0) chk("ack spacing", 64'(ack_cyc - prev), 64'd3);
         prev = ack_cyc;
      end
      i_req = 1'b0;
      d_req = 1'b0;

      // response in the final allowed WAIT cycle succeeds without error
      do_reset();
      raise_d(1'b0, 32'h440, 32'h0);
      serve(TO, 1'b0, 32'h0, 1'b0);
      chk("late ok err", {63'd0, err}, 64'd0);

      // no response at all: abort, zero data, sticky error
      raise_d(1'b0, 32'h480, 32'h0);
      serve(TO + 1, 1'b0, 32'h0, 1'b0);
      chk("timeout err", {63'd0, err}, 64'd1);
      chk("timeout rdata", d_rdata, 0);
      raise_i(32'h500);
      serve(2, 1'b0, 32'h0, 1'b0);
      raise_d(1'b1, 32'h504, 32'h1234_5678);
      serve(1, 1'b0, 32'h0, 1'b0);
      chk("err sticky", {63'd0, err}, 64'd1);

      // reset in the middle of a WAIT
      raise_i(32'h600);
      @(posedge clk); #1;
      chk("mid grant", {63'd0, m_req}, 64'd1);
      @(posedge clk); #1;
      rst   = 1'b0;
      i_req = 1'b0;
      @(posedge clk); #1;
      chk("mid reset ctl", {59'd0, m_req, m_we, i_ack, d_ack, busy, err}, 64'd0);
      rst     = 1'b1;
      last    = 1'b0;
      exp_err = 1'b0;
      @(posedge clk); #1;
      chk("post reset idle", {62'd0, busy, i_ack}, 64'd0);
      raise_i(32'h700);
      serve(2, 1'b1, 32'hCAFE_F00D, 1'b0);
      chk("post reset rdata", i_rdata, 32'hCAFE_F00D);

      // randomized traffic against the model
      for (int n = 0; n < 40; n++) begin
         if (!i_req && ($urandom_range(0, 1) == 1)) raise_i($urandom);
         if (!d_req && ($urandom_range(0, 1) == 1)) raise_d(1'($urandom), $urandom, $urandom);
         if (!i_req && !d_req) raise_d(1'($urandom), $urandom, $urandom);
         serve($urandom_range(1, TO + 1), 1'b0, 32'h0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
